uart_receiver: RTL and testbench
================================

UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter CLOCK_RATE, default 48000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 clk  input  1  sole clock, all logic rising-edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 en  input  1  receive enable.
REQ-006 in  input  1  asynchronous serial line, idle high.
REQ-007 out  output  8  last received data byte.
REQ-008 valid  output  1  out holds an unconsumed byte.
REQ-009 ready  input  1  consumer accepts the byte in any cycle where valid && ready.
REQ-010 err  output  1  framing error flag.

Function
REQ-011 CLKS_PER_BIT SHALL equal CLOCK_RATE/BAUD_RATE, integer-truncated (416 at defaults); HALF_BIT SHALL equal CLKS_PER_BIT/2 (208).
REQ-012 in SHALL pass through a 2-flop synchronizer before any use; rxs denotes the synchronized line.
REQ-013 States SHALL be IDLE, START, DATA, STOP and HOLD.
REQ-014 IDLE: rxs==0 with en==1 SHALL move to START and clear the bit counter (cycle t0).
REQ-015 START: at t0+HALF_BIT, rxs==0 SHALL move to DATA; rxs==1 SHALL treat the edge as a glitch and return to IDLE with no flag change.
REQ-016 DATA: 8 bits SHALL be sampled LSB first, bit k (k=0..7) at t0+HALF_BIT+(k+1)*CLKS_PER_BIT, then move to STOP.
REQ-017 STOP: rxs is sampled at t0+HALF_BIT+9*CLKS_PER_BIT (t0+3952 at defaults).
REQ-018 STOP with rxs==1: out SHALL load the byte, and valid SHALL rise and err SHALL clear on the following edge; state SHALL move to HOLD.
REQ-019 STOP with rxs==0: err SHALL set, out and valid SHALL be unchanged, and state SHALL return to IDLE.
REQ-020 Latency: valid high at most 3955 clocks after the falling edge of in at defaults; 2 synchronizer cycles are included.
REQ-021 HOLD: valid SHALL remain 1 until a cycle with ready==1; valid SHALL drop on the next edge and state SHALL return to IDLE in the same edge.
REQ-022 With ready held 1, valid SHALL be exactly one cycle wide.
REQ-023 Start edges arriving while in HOLD SHALL be ignored and are not received (overrun drop, no flag).
REQ-024 After a frame with rxs high, the next start edge SHALL be accepted the cycle after return to IDLE, so back-to-back frames with a one-bit stop are received.
REQ-025 err SHALL stay set until the next successfully received byte.
REQ-026 en==0 SHALL force START/DATA/STOP to IDLE on the next edge, abandoning the partial byte; HOLD, valid, out and err SHALL be unaffected.
REQ-027 Bit timer and bit counter SHALL be unsigned and sized for CLKS_PER_BIT and 0..8 respectively, with no wrap-around during a frame.

Reset
REQ-028 rst_n low SHALL immediately set state IDLE, out=0x00, valid=0, err=0, clear timer and counter, and preset both synchronizer flops to 1.
REQ-029 Reset asserted mid-frame SHALL discard the frame; after release, reception SHALL resume only from a new falling edge.

Structure
REQ-030 A shared package uart_pkg SHALL hold the state enumeration and the CLKS_PER_BIT/HALF_BIT derivation functions, for reuse by the matching transmitter.
REQ-031 One sub-module, uart_sync2 (2-flop synchronizer, reset value 1), SHALL be instantiated; all other logic stays flat.

Verification
REQ-032 Send 0x55 with 8N1 at 115200 and ready=1 -> out=0x55, valid high exactly 1 cycle within 3955 clocks of the start edge, err=0.
REQ-033 Send 0x30 with ready=0, raise ready 1000 clocks after valid -> valid held high until the cycle after ready; out stays 0x30.
REQ-034 Send 0xA5 with stop bit driven 0 -> err=1, valid stays 0; then send 0x20 -> out=0x20, valid pulse, err=0.
REQ-035 Pulse in low for 100 clocks -> no valid and no err; then send 0x31 -> out=0x31.
REQ-036 Send back-to-back 0x31 then 0x20 with ready=1 -> two valid pulses, values 0x31 then 0x20.
REQ-037 Assert rst_n low during bit 4 of a frame, then send 0x48 -> outputs zero during reset, then out=0x48; with en=0 during a frame -> no valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver and the matching transmitter.
//   uart_state_e  : frame-level state enumeration
//   clks_per_bit  : system clocks per serial bit (integer-truncated)
//   half_bit      : clocks from the start edge to the middle of the start bit
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    HOLD  = 3'd4
  } uart_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned clock_rate,
                                               input int unsigned baud_rate);
    return clock_rate / baud_rate;
  endfunction

  function automatic int unsigned half_bit(input int unsigned clock_rate,
                                           input int unsigned baud_rate);
    return clks_per_bit(clock_rate, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous, idle-high serial line.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset; both flops preset to 1 (line idle)
//   d_i    : asynchronous input
//   q_o    : synchronized output
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with a one-byte holding register and valid/ready handoff.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   en    : receive enable; dropping it abandons a frame in progress
//   in    : asynchronous serial line, idle high
//   out   : last received data byte
//   valid : out holds a byte not yet accepted
//   ready : consumer accepts the byte in any cycle with valid && ready
//   err   : framing error, sticky until the next good byte
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_RATE = 48000000,
  parameter int unsigned BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       in,
  output logic [7:0] out,
  output logic       valid,
  input  logic       ready,
  output logic       err
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLOCK_RATE, BAUD_RATE);
  localparam int unsigned HALF_BIT     = half_bit(CLOCK_RATE, BAUD_RATE);
  localparam int          TMR_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // The timer counts edges since the last sample point, so the sample edge is
  // the one where the timer already holds N-1.
  localparam logic [TMR_W-1:0] HALF_LAST = TMR_W'(HALF_BIT - 1);
  localparam logic [TMR_W-1:0] BIT_LAST  = TMR_W'(CLKS_PER_BIT - 1);

  logic rxs;

  uart_sync2 u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (in),
    .q_o    (rxs)
  );

  uart_state_e      state_q,  state_d;
  logic [TMR_W-1:0] timer_q,  timer_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q,  shift_d;
  logic [7:0]       out_q,    out_d;
  logic             err_q,    err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
      out_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      out_q    <= out_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    out_d    = out_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (en && !rxs) begin
          state_d  = START;
          timer_d  = '0;
          bitcnt_d = '0;
        end
      end
      START: begin
        if (!en) begin
          state_d = IDLE;
        end else if (timer_q == HALF_LAST) begin
          timer_d = '0;
          // Line back high at mid start bit: a glitch, not a frame.
          state_d = rxs ? IDLE : DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        if (!en) begin
          state_d = IDLE;
        end else if (timer_q == BIT_LAST) begin
          timer_d  = '0;
          shift_d  = {rxs, shift_q[7:1]};  // LSB arrives first
          bitcnt_d = bitcnt_q + 4'd1;
          if (bitcnt_q == 4'd7) begin
            state_d = STOP;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        if (!en) begin
          state_d = IDLE;
        end else if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rxs) begin
            out_d   = shift_q;
            err_d   = 1'b0;
            state_d = HOLD;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      HOLD: begin
        // Start edges seen here are deliberately dropped (overrun).
        if (ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid = (state_q == HOLD);
    out   = out_q;
    err   = err_q;
  end

endmodule

// File: tb/tb_uart_receiver.sv
module tb_uart_receiver;

  localparam int CLOCK_RATE = 48000000;
  localparam int BAUD_RATE  = 115200;
  localparam int CPB        = CLOCK_RATE / BAUD_RATE;  // 416
  localparam int MAX_LAT    = 3955;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       in    = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] out;
  logic       valid;
  logic       err;

  uart_receiver #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .in    (in),
    .out   (out),
    .valid (valid),
    .ready (ready),
    .err   (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Record every rising edge of valid (byte + cycle) and count valid-high cycles.
  logic [7:0] rx_q[$];
  int         rx_cyc[$];
  int         valid_cycles = 0;
  logic       valid_prev = 1'b0;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      if (!valid_prev) begin
        rx_q.push_back(out);
        rx_cyc.push_back(cyc);
      end
      valid_cycles++;
    end
    valid_prev = (valid === 1'b1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic clear_rx();
    rx_q.delete();
    rx_cyc.delete();
  endtask

  // One 8N1 frame; after a bad stop bit an idle bit is added so the next
  // start edge is unambiguous.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    @(negedge clk);
    in = 1'b0;
    start_cyc = cyc;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      in = b[i];
      repeat (CPB) @(negedge clk);
    end
    in = stop_bit;
    repeat (CPB) @(negedge clk);
    in = 1'b1;
    if (!stop_bit) repeat (CPB) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (out !== 8'h00) $display("FAIL reset_out: got %h want 00", out); else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else n_pass++;
    rst_n = 1'b1;
    en    = 1'b1;
    ready = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (valid !== 1'b0) $display("FAIL idle_valid: got %b want 0", valid); else n_pass++;
  endtask

  task automatic test_basic();
    int s, v0, lat;
    logic [7:0] got;
    ready = 1'b1;
    clear_rx();
    v0 = valid_cycles;
    send_frame(8'h55, 1'b1, s);
    n_checks++; if (rx_q.size() != 1) $display("FAIL basic_count: got %0d want 1", rx_q.size()); else n_pass++;
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    n_checks++; if (got !== 8'h55) $display("FAIL basic_data: got %h want 55", got); else n_pass++;
    lat = (rx_cyc.size() > 0) ? rx_cyc[0] - s : -1;
    n_checks++;
    if (lat < 0 || lat > MAX_LAT) $display("FAIL basic_latency: got %0d want <= %0d", lat, MAX_LAT);
    else n_pass++;
    n_checks++; if (valid_cycles - v0 != 1) $display("FAIL basic_width: got %0d want 1", valid_cycles - v0); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL basic_err: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_hold();
    int s, v0, t;
    ready = 1'b0;
    clear_rx();
    v0 = valid_cycles;
    send_frame(8'h30, 1'b0 ^ 1'b1, s);
    n_checks++;
    if (rx_cyc.size() == 0) begin
      $display("FAIL hold_rise: got no valid want valid");
      ready = 1'b1;
      return;
    end
    n_pass++;
    t = rx_cyc[0];
    while (cyc < t + 1000) @(negedge clk);
    n_checks++; if (valid !== 1'b1) $display("FAIL hold_valid: got %b want 1", valid); else n_pass++;
    n_checks++; if (out !== 8'h30) $display("FAIL hold_data: got %h want 30", out); else n_pass++;
    ready = 1'b1;
    @(negedge clk);
    n_checks++; if (valid !== 1'b0) $display("FAIL hold_drop: got %b want 0", valid); else n_pass++;
    n_checks++; if (out !== 8'h30) $display("FAIL hold_keep: got %h want 30", out); else n_pass++;
    n_checks++;
    if (valid_cycles - v0 != 1001) $display("FAIL hold_width: got %0d want 1001", valid_cycles - v0);
    else n_pass++;
  endtask

  task automatic test_framing();
    int s;
    logic [7:0] got;
    ready = 1'b1;
    clear_rx();
    send_frame(8'hA5, 1'b0, s);
    n_checks++; if (err !== 1'b1) $display("FAIL frame_err_set: got %b want 1", err); else n_pass++;
    n_checks++; if (rx_q.size() != 0) $display("FAIL frame_no_valid: got %0d want 0", rx_q.size()); else n_pass++;
    n_checks++; if (out !== 8'h30) $display("FAIL frame_out_kept: got %h want 30", out); else n_pass++;
    send_frame(8'h20, 1'b1, s);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    n_checks++; if (got !== 8'h20) $display("FAIL frame_recover: got %h want 20", got); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL frame_err_clr: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_glitch();
    int s;
    logic [7:0] got;
    clear_rx();
    @(negedge clk);
    in = 1'b0;
    repeat (100) @(negedge clk);
    in = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_checks++; if (rx_q.size() != 0) $display("FAIL glitch_valid: got %0d want 0", rx_q.size()); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("FAIL glitch_err: got %b want 0", err); else n_pass++;
    send_frame(8'h31, 1'b1, s);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    n_checks++; if (got !== 8'h31) $display("FAIL glitch_after: got %h want 31", got); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int s, v0;
    logic [7:0] g0, g1;
    clear_rx();
    v0 = valid_cycles;
    send_frame(8'h31, 1'b1, s);
    send_frame(8'h20, 1'b1, s);
    n_checks++; if (rx_q.size() != 2) $display("FAIL b2b_count: got %0d want 2", rx_q.size()); else n_pass++;
    g0 = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    g1 = (rx_q.size() > 1) ? rx_q[1] : 8'hxx;
    n_checks++; if (g0 !== 8'h31) $display("FAIL b2b_first: got %h want 31", g0); else n_pass++;
    n_checks++; if (g1 !== 8'h20) $display("FAIL b2b_second: got %h want 20", g1); else n_pass++;
    n_checks++; if (valid_cycles - v0 != 2) $display("FAIL b2b_width: got %0d want 2", valid_cycles - v0); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int s;
    logic [7:0] got;
    clear_rx();
    // 0xF0: bits 4..7 and stop are high, so no falling edge follows bit 3.
    fork
      send_frame(8'hF0, 1'b1, s);
      begin
        repeat (CPB * 5 + CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (out !== 8'h00) $display("FAIL midrst_out: got %h want 00", out); else n_pass++;
        n_checks++; if (valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", valid); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL midrst_err: got %b want 0", err); else n_pass++;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    n_checks++; if (rx_q.size() != 0) $display("FAIL midrst_discard: got %0d want 0", rx_q.size()); else n_pass++;
    send_frame(8'h48, 1'b1, s);
    got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
    n_checks++; if (got !== 8'h48) $display("FAIL midrst_resume: got %h want 48", got); else n_pass++;
  endtask

  task automatic test_enable();
    int s;
    logic [7:0] b;
    b = 8'($urandom);
    clear_rx();
    fork
      send_frame(b, 1'b1, s);
      begin
        repeat (1500) @(negedge clk);
        en = 1'b0;
      end
    join
    n_checks++; if (rx_q.size() != 0) $display("FAIL en_abandon: got %0d want 0", rx_q.size()); else n_pass++;
    n_checks++; if (out !== 8'h48) $display("FAIL en_out_kept: got %h want 48", out); else n_pass++;
    en = 1'b1;
  endtask

  // Reference model: a frame yields its byte iff the stop bit is 1;
  // otherwise no byte and the error flag is set.
  task automatic test_random();
    int s;
    logic [7:0] b, got;
    logic stop_bit;
    for (int n = 0; n < 4; n++) begin
      b = 8'($urandom);
      stop_bit = ($urandom_range(0, 3) != 0);
      clear_rx();
      send_frame(b, stop_bit, s);
      if (stop_bit) begin
        got = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        n_checks++; if (got !== b) $display("FAIL rand_data[%0d]: got %h want %h", n, got, b); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rand_err[%0d]: got %b want 0", n, err); else n_pass++;
      end else begin
        n_checks++; if (rx_q.size() != 0) $display("FAIL rand_novalid[%0d]: got %0d want 0", n, rx_q.size()); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL rand_errset[%0d]: got %b want 1", n, err); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_enable();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
